// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the byte-oriented SPI slave.
package spi_slave_pkg;

    localparam int unsigned BYTE_W = 8;

    // Encoded as {cpol, cpha}.
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_slv_state_t;

    // Sample edge: leading edge for cpha=0, trailing edge for cpha=1.
    function automatic logic sample_edge(input spi_mode_t mode, input logic rise, input logic fall);
        logic hit;
        hit = 1'b0;
        case (mode)
            MODE0, MODE3: hit = rise;
            MODE1, MODE2: hit = fall;
            default:      hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic shift_edge(input spi_mode_t mode, input logic rise, input logic fall);
        logic hit;
        hit = 1'b0;
        case (mode)
            MODE0, MODE3: hit = fall;
            MODE1, MODE2: hit = rise;
            default:      hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage synchronizer for one asynchronous SPI pin, with edge strobes
// derived from the synchronized level and its previous value.
module spi_pin_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign level  = chain[STAGES-1];
    assign rise_c = chain[STAGES-1] & ~prev;
    assign fall_c = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_slave_byte.sv
// Oversampled SPI slave, all four CPOL/CPHA modes, MSB first, with a
// one-deep transmit buffer and per-byte receive strobe.
module spi_slave_byte
    import spi_slave_pkg::*;
#(
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0] IDLE_TX     = 8'h00
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              sck_i,
    input  logic              ss_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    input  logic [BYTE_W-1:0] tx_data_i,
    input  logic              tx_load_i,
    output logic              tx_ready_o,
    output logic              tx_underrun_o,
    output logic [BYTE_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              frame_err_o,
    output logic              busy_o
);

    localparam int unsigned CNT_W = $clog2(BYTE_W);

    logic sck_lvl, sck_rise, sck_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic pins_unused;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk_i), .rst(rst_i), .d(sck_i),
        .level(sck_lvl), .rise_c(sck_rise), .fall_c(sck_fall)
    );

    // ss_n resets as asserted so a frame already running at reset release
    // shows no falling edge and is ignored until the master reselects.
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ss (
        .clk(clk_i), .rst(rst_i), .d(ss_n_i),
        .level(ss_lvl), .rise_c(ss_rise), .fall_c(ss_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk_i), .rst(rst_i), .d(mosi_i),
        .level(mosi_lvl), .rise_c(mosi_rise), .fall_c(mosi_fall)
    );

    assign pins_unused = sck_lvl ^ ss_rise ^ mosi_rise ^ mosi_fall;

    spi_mode_t mode_c;
    logic      sample_c;
    logic      shift_c;

    assign mode_c   = spi_mode_t'({cpol_i, cpha_i});
    assign sample_c = sample_edge(mode_c, sck_rise, sck_fall);
    assign shift_c  = shift_edge(mode_c, sck_rise, sck_fall);

    spi_slv_state_t    state, state_nxt;
    logic [CNT_W-1:0]  bitcnt, bitcnt_nxt;
    logic [BYTE_W-2:0] rx_sh, rx_sh_nxt;
    logic [BYTE_W-1:0] tx_sh, tx_sh_nxt;
    logic [BYTE_W-1:0] tx_buf, tx_buf_nxt;
    logic [BYTE_W-1:0] rx_data_nxt;
    logic [BYTE_W-1:0] rx_byte_c;
    logic [BYTE_W-1:0] load_word_c;
    logic              reload, reload_nxt;
    logic              first, first_nxt;
    logic              consume;
    logic              accept;
    logic              tx_ready_nxt;
    logic              underrun_nxt;
    logic              rx_valid_nxt;
    logic              frame_err_nxt;

    assign rx_byte_c   = {rx_sh, mosi_lvl};
    assign load_word_c = tx_ready_o ? IDLE_TX : tx_buf;

    // Next-state, shifters and transmit buffer.
    always_comb begin
        state_nxt     = state;
        bitcnt_nxt    = bitcnt;
        rx_sh_nxt     = rx_sh;
        tx_sh_nxt     = tx_sh;
        reload_nxt    = reload;
        first_nxt     = first;
        rx_data_nxt   = rx_data_o;
        rx_valid_nxt  = 1'b0;
        frame_err_nxt = 1'b0;
        consume       = 1'b0;

        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_nxt  = ACTIVE;
                    consume    = 1'b1;
                    bitcnt_nxt = '0;
                    reload_nxt = 1'b0;
                    first_nxt  = cpha_i;
                end
            end
            ACTIVE: begin
                if (ss_lvl) begin
                    state_nxt     = IDLE;
                    frame_err_nxt = (bitcnt != '0);
                    bitcnt_nxt    = '0;
                    reload_nxt    = 1'b0;
                    first_nxt     = 1'b0;
                end else if (sample_c) begin
                    rx_sh_nxt = rx_byte_c[BYTE_W-2:0];
                    if (bitcnt == CNT_W'(BYTE_W - 1)) begin
                        rx_data_nxt  = rx_byte_c;
                        rx_valid_nxt = 1'b1;
                        bitcnt_nxt   = '0;
                        reload_nxt   = 1'b1;
                    end else begin
                        bitcnt_nxt = bitcnt + CNT_W'(1);
                    end
                end else if (shift_c) begin
                    // With cpha=1 the first leading edge must keep the freshly loaded MSB.
                    if (first) begin
                        first_nxt = 1'b0;
                    end else if (reload) begin
                        consume    = 1'b1;
                        reload_nxt = 1'b0;
                    end else begin
                        tx_sh_nxt = {tx_sh[BYTE_W-2:0], 1'b0};
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (consume) begin
            tx_sh_nxt = load_word_c;
        end

        // A write in the consume cycle lands in the buffer behind the outgoing byte.
        accept       = tx_load_i && (tx_ready_o || consume);
        tx_buf_nxt   = accept ? tx_data_i : tx_buf;
        underrun_nxt = consume && tx_ready_o;
        if (accept) begin
            tx_ready_nxt = 1'b0;
        end else if (consume) begin
            tx_ready_nxt = 1'b1;
        end else begin
            tx_ready_nxt = tx_ready_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            bitcnt        <= '0;
            rx_sh         <= '0;
            tx_sh         <= '0;
            tx_buf        <= '0;
            reload        <= 1'b0;
            first         <= 1'b0;
            tx_ready_o    <= 1'b1;
            tx_underrun_o <= 1'b0;
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
            frame_err_o   <= 1'b0;
            busy_o        <= 1'b0;
            miso_o        <= 1'b0;
            miso_oe_o     <= 1'b0;
        end else begin
            state         <= state_nxt;
            bitcnt        <= bitcnt_nxt;
            rx_sh         <= rx_sh_nxt;
            tx_sh         <= tx_sh_nxt;
            tx_buf        <= tx_buf_nxt;
            reload        <= reload_nxt;
            first         <= first_nxt;
            tx_ready_o    <= tx_ready_nxt;
            tx_underrun_o <= underrun_nxt;
            rx_data_o     <= rx_data_nxt;
            rx_valid_o    <= rx_valid_nxt;
            frame_err_o   <= frame_err_nxt;
            busy_o        <= (state_nxt == ACTIVE);
            miso_o        <= (state_nxt == ACTIVE) && tx_sh_nxt[BYTE_W-1];
            miso_oe_o     <= (state_nxt == ACTIVE);
        end
    end

endmodule
